// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the fifo_buf block and its consumers.
//   - default data/address widths
//   - clog2-style helper for sizing counters from a depth
//   - fifo_status_t: bundled status flags, plus its reset value
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 8;

  // Number of bits needed to index 'value' distinct items (minimum 1).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Status seen while the FIFO is held in reset: nothing stored, no errors.
  localparam fifo_status_t FIFO_STATUS_RST = '{
    empty:        1'b1,
    full:         1'b0,
    almost_empty: 1'b1,
    almost_full:  1'b0,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/pulse_edge_det.sv
// pulse_edge_det
// Two-flop release detector. Produces a one-cycle pulse after the input
// falls, so a request held high for any number of cycles counts once.
// Ports:
//   clock   in  rising-edge clock
//   reset_n in  asynchronous active-low reset (both flops clear to 0)
//   sig     in  raw request level
//   pulse   out high for the cycle following the first edge that sampled
//               sig low after it had been high
module pulse_edge_det (
  input  logic clock,
  input  logic reset_n,
  input  logic sig,
  output logic pulse
);

  logic q1;
  logic q2;

  // q1 is the newest sample of the request and q2 the one before it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= sig;
      q2 <= q1;
    end
  end

  // High-to-low transition seen across the two samples.
  assign pulse = ~q1 & q2;

endmodule

// File: rtl/fifo_buf.sv
// fifo_buf
// Single-clock FIFO with a registered read port, occupancy count,
// programmable almost-empty/almost-full thresholds and sticky
// overflow/underflow flags. All status outputs are registered.
//
// Optional feature macro: FIFO_EDGE_DETECT_EN
//   defined   -> wr/rd are release-detected, one operation per press
//   undefined -> wr/rd are per-cycle level strobes
//
// Parameters:
//   DATA_W  data word width
//   ADDR_W  address bits, depth is 2**ADDR_W (every entry usable)
//   AE_LVL  almost_empty when level <= AE_LVL
//   AF_LVL  almost_full  when level >= AF_LVL
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   wr, rd       in   write / read requests
//   din          in   write data, sampled at the committing edge
//   err_clr      in   synchronous clear of the sticky error flags
//   dout         out  registered read data, holds until the next read
//   rd_valid     out  one-cycle pulse, dout updated at the preceding edge
//   empty, full  out  level == 0 / level == DEPTH
//   almost_empty out  threshold flag
//   almost_full  out  threshold flag
//   level        out  occupancy 0..DEPTH
//   overflow     out  sticky, a write was rejected while full
//   underflow    out  sticky, a read was rejected while empty
module fifo_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int AE_LVL = 1,
  parameter int AF_LVL = (1 << ADDR_W) - 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;

  // Thresholds sized to the pointer width so comparisons stay unsigned.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AE_THR    = (ADDR_W + 1)'(AE_LVL);
  localparam logic [ADDR_W:0] AF_THR    = (ADDR_W + 1)'(AF_LVL);

  logic              wr_s;
  logic              rd_s;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wp;
  logic [ADDR_W:0]   rp;
  logic [ADDR_W:0]   wp_n;
  logic [ADDR_W:0]   rp_n;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_n;

  logic              wr_acc;
  logic              rd_acc;
  logic              wr_rej;
  logic              rd_rej;

  fifo_status_t      status_q;
  fifo_status_t      status_n;

  logic [DATA_W-1:0] dout_q;
  logic              rd_valid_q;

`ifdef FIFO_EDGE_DETECT_EN
  // Each request counts once, on its release.
  pulse_edge_det u_wr_det (
    .clock   (clock),
    .reset_n (reset_n),
    .sig     (wr),
    .pulse   (wr_s)
  );

  pulse_edge_det u_rd_det (
    .clock   (clock),
    .reset_n (reset_n),
    .sig     (rd),
    .pulse   (rd_s)
  );
`else
  assign wr_s = wr;
  assign rd_s = rd;
`endif

  // A read only needs data to be present. A write needs space, but when
  // full a simultaneous accepted read frees the slot in the same cycle.
  always_comb begin
    rd_acc = rd_s & ~status_q.empty;
    wr_acc = wr_s & (~status_q.full | rd_acc);
    wr_rej = wr_s & ~wr_acc;
    rd_rej = rd_s & status_q.empty;
  end

  // Next pointers and occupancy. The extra pointer MSB makes wp - rp
  // distinguish a full buffer from an empty one, and the modulo
  // subtraction handles wrap without any special case.
  always_comb begin
    wp_n    = wp + {{ADDR_W{1'b0}}, wr_acc};
    rp_n    = rp + {{ADDR_W{1'b0}}, rd_acc};
    level_n = wp_n - rp_n;
  end

  // Flags are derived from the next-state level so they line up with
  // the level register. A new error beats err_clr in the same cycle.
  always_comb begin
    status_n              = FIFO_STATUS_RST;
    status_n.empty        = (level_n == '0);
    status_n.full         = (level_n == DEPTH_CNT);
    status_n.almost_empty = (level_n <= AE_THR);
    status_n.almost_full  = (level_n >= AF_THR);
    status_n.overflow     = wr_rej | (status_q.overflow & ~err_clr);
    status_n.underflow    = rd_rej | (status_q.underflow & ~err_clr);
  end

  // Pointer, level and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp       <= '0;
      rp       <= '0;
      level_q  <= '0;
      status_q <= FIFO_STATUS_RST;
    end else begin
      wp       <= wp_n;
      rp       <= rp_n;
      level_q  <= level_n;
      status_q <= status_n;
    end
  end

  // Storage array is not reset. When full with a simultaneous read and
  // write, both pointers index the same slot: the read below sees the old
  // word and this write replaces it, which is the intended order.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wp[ADDR_W-1:0]] <= din;
    end
  end

  // Registered read port. dout holds until the next accepted read, so a
  // word written into an empty FIFO never appears here without a read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        dout_q <= mem[rp[ADDR_W-1:0]];
      end
    end
  end

  assign dout         = dout_q;
  assign rd_valid     = rd_valid_q;
  assign level        = level_q;
  assign empty        = status_q.empty;
  assign full         = status_q.full;
  assign almost_empty = status_q.almost_empty;
  assign almost_full  = status_q.almost_full;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_fifo_buf.sv
// tb_fifo_buf
// Directed bench for fifo_buf with DATA_W=8, ADDR_W=3 (depth 8),
// AE_LVL=1, AF_LVL=7. Inputs change 1 time unit after each rising edge
// and outputs are sampled at the same point. With FIFO_EDGE_DETECT_EN
// defined the release-detect sequence runs instead of the level sequence.
module tb_fifo_buf;

  logic       clock;
  logic       reset_n;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic       err_clr;
  logic [7:0] dout;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [3:0] level;
  logic       overflow;
  logic       underflow;

  int checks_total;
  int checks_passed;

  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  fifo_buf #(
    .DATA_W (8),
    .ADDR_W (3),
    .AE_LVL (1),
    .AF_LVL (7)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wr           (wr),
    .rd           (rd),
    .din          (din),
    .err_clr      (err_clr),
    .dout         (dout),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle and land just after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic w, input logic r, input logic [7:0] d,
                                input logic clr);
    wr      = w;
    rd      = r;
    din     = d;
    err_clr = clr;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_empty"}, 16'(empty), 16'h1);
    check_output({tag, "_full"}, 16'(full), 16'h0);
    check_output({tag, "_aempty"}, 16'(almost_empty), 16'h1);
    check_output({tag, "_afull"}, 16'(almost_full), 16'h0);
    check_output({tag, "_level"}, 16'(level), 16'h0);
    check_output({tag, "_dout"}, 16'(dout), 16'h00);
    check_output({tag, "_rdvalid"}, 16'(rd_valid), 16'h0);
    check_output({tag, "_ovf"}, 16'(overflow), 16'h0);
    check_output({tag, "_unf"}, 16'(underflow), 16'h0);
  endtask

  // Watchdog: the directed sequence is short, so this only fires on a hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset_n       = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    step(2);
    check_reset_outputs("in_reset");
    reset_n = 1'b1;
    step(4);
    check_reset_outputs("idle");

`ifdef FIFO_EDGE_DETECT_EN
    // Hold wr for 5 cycles, then release: one write two edges later.
    apply_stimulus(1'b1, 1'b0, 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_output($sformatf("hold_wr_level%0d", i), 16'(level), 16'h0);
    end
    wr = 1'b0;
    step();
    check_output("release_edge1_level", 16'(level), 16'h0);
    step();
    check_output("release_edge2_level", 16'(level), 16'h1);
    check_output("release_edge2_empty", 16'(empty), 16'h0);
    step(3);
    check_output("single_write_level", 16'(level), 16'h1);

    // One-cycle rd press: the read lands two edges after release.
    rd = 1'b1;
    step();
    rd = 1'b0;
    step();
    check_output("rd_edge1_valid", 16'(rd_valid), 16'h0);
    step();
    check_output("rd_edge2_valid", 16'(rd_valid), 16'h1);
    check_output("rd_edge2_dout", 16'(dout), 16'h3C);
    check_output("rd_edge2_level", 16'(level), 16'h0);

    // Two stored presses, then reset while a third is held.
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0);
      step();
      wr = 1'b0;
      step(2);
    end
    check_output("burst_level", 16'(level), 16'h2);
    wr = 1'b1;
    step(2);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_burst_reset");
    wr = 1'b0;
    step();
    reset_n = 1'b1;
    step(3);
    check_output("post_reset_no_pulse", 16'(level), 16'h0);
`else
    // Fill 0x10..0x17 and watch the threshold flags move.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
      step();
      check_output($sformatf("fill_level%0d", i), 16'(level), 16'(i + 1));
      check_output($sformatf("fill_aempty%0d", i), 16'(almost_empty), 16'((i + 1) <= 1));
      check_output($sformatf("fill_afull%0d", i), 16'(almost_full), 16'((i + 1) >= 7));
      check_output($sformatf("fill_full%0d", i), 16'(full), 16'((i + 1) == 8));
    end
    apply_stimulus(1'b1, 1'b0, 8'hFF, 1'b0);
    step();
    check_output("ovf_flag", 16'(overflow), 16'h1);
    check_output("ovf_level", 16'(level), 16'h8);
    check_output("ovf_full", 16'(full), 16'h1);

    // Drain: FIFO order, rejected 0xFF must not appear.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
      step();
      check_output($sformatf("drain_dout%0d", i), 16'(dout), 16'h10 + 16'(i));
      check_output($sformatf("drain_valid%0d", i), 16'(rd_valid), 16'h1);
      check_output($sformatf("drain_level%0d", i), 16'(level), 16'(7 - i));
    end
    check_output("drain_empty", 16'(empty), 16'h1);
    step();
    check_output("unf_flag", 16'(underflow), 16'h1);
    check_output("unf_valid", 16'(rd_valid), 16'h0);
    check_output("unf_dout_hold", 16'(dout), 16'h17);
    check_output("unf_ovf_sticky", 16'(overflow), 16'h1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check_output("clr_ovf", 16'(overflow), 16'h0);
    check_output("clr_unf", 16'(underflow), 16'h0);

    // Fill, then 20 cycles of simultaneous write+read across the wrap.
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
      exp_q.push_back(8'h20 + 8'(i));
      step();
    end
    check_output("refill_full", 16'(full), 16'h1);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 1'b1, 8'h30 + 8'(i), 1'b0);
      exp_q.push_back(8'h30 + 8'(i));
      exp_word = exp_q.pop_front();
      step();
      check_output($sformatf("stream_dout%0d", i), 16'(dout), 16'(exp_word));
      check_output($sformatf("stream_level%0d", i), 16'(level), 16'h8);
      check_output($sformatf("stream_full%0d", i), 16'(full), 16'h1);
    end
    check_output("stream_no_ovf", 16'(overflow), 16'h0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
      exp_word = exp_q.pop_front();
      step();
      check_output($sformatf("tail_dout%0d", i), 16'(dout), 16'(exp_word));
    end
    check_output("tail_last", 16'(dout), 16'h43);

    // Simultaneous write+read while empty: write only, underflow.
    apply_stimulus(1'b1, 1'b1, 8'hA5, 1'b0);
    step();
    check_output("empty_wr_rd_level", 16'(level), 16'h1);
    check_output("empty_wr_rd_unf", 16'(underflow), 16'h1);
    check_output("empty_wr_rd_valid", 16'(rd_valid), 16'h0);
    check_output("empty_wr_rd_dout", 16'(dout), 16'h43);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check_output("errclr_unf", 16'(underflow), 16'h0);

    // A new underflow in the same cycle as err_clr keeps the flag set.
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    check_output("read_a5", 16'(dout), 16'hA5);
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b1);
    step();
    check_output("err_beats_clr", 16'(underflow), 16'h1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check_output("clr_after", 16'(underflow), 16'h0);

    // Reset mid-operation discards contents; next write goes to slot 0.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'h50 + 8'(i), 1'b0);
      step();
    end
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("pre_reset_level", 16'(level), 16'h3);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_op_reset");
    step();
    reset_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'h60, 1'b0);
    step();
    check_output("post_reset_level", 16'(level), 16'h1);
    apply_stimulus(1'b0, 1'b1, 8'h00, 1'b0);
    step();
    check_output("post_reset_dout", 16'(dout), 16'h60);
    check_output("post_reset_empty", 16'(empty), 16'h1);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
`endif

    step(2);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fifo_buf.md
# fifo_buf

Parametrised synchronous FIFO with a registered read port, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags. It is the general-purpose buffer between request producers (button front-ends, UART receivers) and consumers in the single-clock domain. All status outputs are registered, so it can drive LEDs or downstream logic directly.

## Interface
- `DATA_W`, 8: data word width.
- `ADDR_W`, 8: address bits; depth `DEPTH = 2**ADDR_W` entries, all usable.
- `AE_LVL`, 1: `almost_empty` asserts when `level <= AE_LVL`.
- `AF_LVL`, `2**ADDR_W-1`: `almost_full` asserts when `level >= AF_LVL`.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr` in 1: write request.
- `rd` in 1: read request.
- `din` in DATA_W: write data, sampled at the edge that commits the write.
- `err_clr` in 1: synchronous clear of the sticky error flags.
- `dout` out DATA_W: read data, registered.
- `rd_valid` out 1: one-cycle pulse; `dout` was updated at the preceding edge.
- `empty` out 1: `level == 0`.
- `full` out 1: `level == DEPTH`.
- `almost_empty` out 1: threshold flag.
- `almost_full` out 1: threshold flag.
- `level` out ADDR_W+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was rejected because the FIFO was full.
- `underflow` out 1: sticky; a read was rejected because the FIFO was empty.

## Operation
- Effective strobes `wr_s`/`rd_s` come from `wr`/`rd`. Their derivation is given under Configuration.
- Pointers `wp` and `rp` are ADDR_W+1 bits wide. The RAM index is the low ADDR_W bits; the MSB distinguishes full from empty.
- `level = wp - rp`, computed modulo 2**(ADDR_W+1). All flags derive from the next-state level and are registered.
- Accepted write: `wr_s & (~full | rd_acc)`. Stores `din` at `mem[wp]`, then increments `wp`.
- Accepted read: `rd_s & ~empty`. Loads `dout <= mem[rp]`, increments `rp` and pulses `rd_valid`.
- Simultaneous `wr_s` and `rd_s`:
  - Not empty and not full: both accepted; `level` unchanged.
  - Full: both accepted (the read frees the slot); `full` stays 1; no overflow.
  - Empty: write accepted, read rejected, `underflow` set. The written word is not bypassed to `dout`.
- Rejected write: `wr_s & full & ~rd_acc`. Memory and pointers unchanged; `overflow <= 1`.
- Rejected read: `rd_s & empty`. `dout` holds its value; `rd_valid` stays 0; `underflow <= 1`.
- Pointers wrap naturally from index DEPTH-1 to 0. No other wrap handling is needed.
- `err_clr` clears both sticky flags. If `err_clr` coincides with a new error, the error wins (the flag stays 1).
- `dout` holds its last value until the next accepted read.

## Timing
- Reset values (asynchronous, while `reset_n == 0`):
  - `wp = rp = 0`, `level = 0`
  - `empty = 1`, `full = 0`
  - `almost_empty = 1`, `almost_full = 0`
  - `dout = 0`, `rd_valid = 0`, `overflow = underflow = 0`
  - Edge-detect registers = 0
- Memory contents are not reset.
- Reset mid-operation discards all contents. The first write after release is stored at index 0.
- Write-to-read latency: a word written at edge k is readable at edge k+1 (`empty` falls after edge k).
- Read latency: `rd_s` high before edge k gives `dout` and `rd_valid` valid after edge k.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- Macro: `FIFO_EDGE_DETECT_EN`.
- Defined:
  - `wr` and `rd` each pass through a two-flop detector.
  - The strobe is `~q1 & q2`: one pulse per release (high-to-low) of the input, active in the cycle after the first edge that samples the low input.
  - Holding `wr` or `rd` high for N cycles yields exactly one operation.
  - Both detector flops reset to 0.
- Undefined: `wr_s = wr` and `rd_s = rd`, treated as per-cycle level strobes with no added latency.

## Structure
- Package `fifo_pkg` holds:
  - the default `DATA_W`/`ADDR_W` constants;
  - a `clog2`-style helper;
  - the `fifo_status_t` struct (`empty`, `full`, `almost_empty`, `almost_full`, `overflow`, `underflow`), used by consumers that bundle status.
- Sub-module `pulse_edge_det` (1-bit, `clock`/`reset_n`) is instantiated twice under `FIFO_EDGE_DETECT_EN`.
- The memory array is inferred inline. There is no RAM macro.

## Test plan
All scenarios use `DATA_W=8`, `ADDR_W=3` (`DEPTH=8`), `AE_LVL=1`, `AF_LVL=7`, with the macro undefined unless stated.
- Reset, then idle 4 cycles -> `empty=1`, `almost_empty=1`, `full=0`, `level=0`, `dout=0x00`, `rd_valid=0`.
- Write 0x10..0x17 on 8 consecutive cycles:
  - `almost_empty` falls at level 2;
  - `almost_full` rises at level 7;
  - `full=1` at level 8;
  - a 9th write (0xFF) is rejected: `overflow=1`, `level=8`.
- Read 8 words:
  - `dout` = 0x10..0x17 in order, each with `rd_valid` one cycle after its `rd`;
  - a 9th read: `underflow=1`, `dout` holds 0x17.
- Fill to 8, then assert `wr` and `rd` together for 20 cycles -> `level` stays 8, no overflow, data ordered across pointer wrap.
- When empty, assert `wr` and `rd` together with `din=0xA5` -> `level=1`, `underflow=1`, `rd_valid=0`. Then `err_clr` clears `underflow`.
- With `FIFO_EDGE_DETECT_EN`:
  - hold `wr` high 5 cycles with `din=0x3C`, then release -> exactly one write, committed at the second edge after release (`level=1`);
  - assert `reset_n=0` mid-burst -> all outputs return to reset values immediately.
